// File: rtl/dds_pkg.sv
// dds_pkg: shared types and default widths for the DDS sweep path.
//   sweep_state_e : sweep controller states (IDLE, DWELL)
//   sweep_dir_e   : sweep direction (UP, DOWN)
//   DDS_DIV_W     : default NCO divider width, also used by the NCO
//   DDS_DWELL_W   : default dwell counter width
package dds_pkg;

    localparam int DDS_DIV_W   = 16;
    localparam int DDS_DWELL_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } sweep_state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } sweep_dir_e;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: host/NCO-facing signal bundle of the sweep controller.
//   start, abort          : one-cycle host requests
//   cfg_start_div/stop/step, cfg_dwell, cfg_loop : sweep configuration
//   nco_en, divider       : NCO control
//   busy, step_strobe, done : host-side progress reporting
// Modports: master = host/test side, slave = dds_sweep_ctrl.
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int DIV_W   = DDS_DIV_W,
    parameter int DWELL_W = DDS_DWELL_W
);
    logic               start;
    logic               abort;
    logic [DIV_W-1:0]   cfg_start_div;
    logic [DIV_W-1:0]   cfg_stop_div;
    logic [DIV_W-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_loop;
    logic               nco_en;
    logic [DIV_W-1:0]   divider;
    logic               busy;
    logic               step_strobe;
    logic               done;

    modport master (
        output start, abort, cfg_start_div, cfg_stop_div, cfg_step, cfg_dwell, cfg_loop,
        input  nco_en, divider, busy, step_strobe, done
    );

    modport slave (
        input  start, abort, cfg_start_div, cfg_stop_div, cfg_step, cfg_dwell, cfg_loop,
        output nco_en, divider, busy, step_strobe, done
    );

endinterface

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable down-counter timing how long each divider value is held.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   restart          : load load_val into the counter
//   load_val         : dwell length minus one
//   expire           : counter has reached zero (last cycle of the dwell)
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               restart,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    logic [DWELL_W-1:0] count_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - ONE;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler driving the NCO divider and enable.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : start/abort requests, cfg_* sweep setup, nco_en/divider
//                      to the NCO, busy/step_strobe/done to the host
// Build option: DDS_SWEEP_PINGPONG_EN - in loop mode reverse direction at each
// end point instead of reloading the start value.
//
// state | meaning
// IDLE  | outputs parked, waiting for start
// DWELL | holding current divider; the step decision is made on the last
//       | dwell cycle (timer expire) so stepping costs no extra clock
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int DIV_W   = DDS_DIV_W,
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    dds_sweep_ctrl_if.slave  bus
);

    sweep_state_e       state_q;
    sweep_dir_e         dir_q;
    logic [DIV_W-1:0]   divider_q;
    logic [DIV_W-1:0]   start_div_q;
    logic [DIV_W-1:0]   stop_div_q;
    logic [DIV_W-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               loop_q;
    logic               nco_en_q;
    logic               busy_q;
    logic               step_strobe_q;
    logic               done_q;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic               back_q;     // 1 while travelling from stop back to start
`endif

    logic [DIV_W-1:0]   tgt;
    logic [DIV_W-1:0]   step_tgt;
    logic               step_up;
    logic               at_end;
    logic [DIV_W:0]     sum_w;
    logic [DIV_W:0]     diff_w;
    logic [DIV_W-1:0]   next_div_d;
    logic               expire;
    logic               restart;
    logic [DWELL_W-1:0] dwell_load;

    // Step/clamp: the extra top bit catches overflow (sum) and underflow
    // (diff borrow), both of which clamp onto the target end point.
    always_comb begin
`ifdef DDS_SWEEP_PINGPONG_EN
        tgt      = back_q ? start_div_q : stop_div_q;
        at_end   = (divider_q == tgt);
        step_up  = (dir_q == UP) ^ back_q;
        step_tgt = tgt;
        if (at_end) begin
            step_up  = ~step_up;
            step_tgt = back_q ? stop_div_q : start_div_q;
        end
`else
        tgt      = stop_div_q;
        at_end   = (divider_q == tgt);
        step_up  = (dir_q == UP);
        step_tgt = tgt;
`endif
        sum_w  = {1'b0, divider_q} + {1'b0, step_q};
        diff_w = {1'b0, divider_q} - {1'b0, step_q};
        if (step_up) begin
            next_div_d = (sum_w > {1'b0, step_tgt}) ? step_tgt : sum_w[DIV_W-1:0];
        end else begin
            next_div_d = (diff_w[DIV_W] || (diff_w[DIV_W-1:0] < step_tgt))
                         ? step_tgt : diff_w[DIV_W-1:0];
        end
    end

    // In IDLE the timer loads straight from the input, since the latched copy
    // is being written on the same edge.
    always_comb begin
        dwell_load = (state_q == IDLE) ? bus.cfg_dwell : dwell_q;
        restart    = 1'b0;
        if (!sys_rst && !bus.abort) begin
            if (state_q == IDLE) begin
                restart = bus.start;
            end else begin
                restart = expire && !(at_end && !loop_q);
            end
        end
    end

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .restart  (restart),
        .load_val (dwell_load),
        .expire   (expire)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            dir_q         <= UP;
            divider_q     <= '0;
            start_div_q   <= '0;
            stop_div_q    <= '0;
            step_q        <= '0;
            dwell_q       <= '0;
            loop_q        <= 1'b0;
            nco_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            step_strobe_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            back_q        <= 1'b0;
`endif
        end else begin
            step_strobe_q <= 1'b0;
            done_q        <= 1'b0;
            if (bus.abort) begin
                state_q  <= IDLE;
                nco_en_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            start_div_q <= bus.cfg_start_div;
                            stop_div_q  <= bus.cfg_stop_div;
                            step_q      <= (bus.cfg_step == '0) ? DIV_W'(1) : bus.cfg_step;
                            dwell_q     <= bus.cfg_dwell;
                            loop_q      <= bus.cfg_loop;
                            dir_q       <= (bus.cfg_start_div <= bus.cfg_stop_div) ? UP : DOWN;
                            divider_q   <= bus.cfg_start_div;
                            nco_en_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
                            back_q      <= 1'b0;
`endif
                        end
                    end
                    DWELL: begin
                        if (expire) begin
                            if (at_end && !loop_q) begin
                                state_q  <= IDLE;
                                nco_en_q <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                            end else if (at_end) begin
`ifdef DDS_SWEEP_PINGPONG_EN
                                divider_q <= next_div_d;
                                back_q    <= ~back_q;
`else
                                divider_q <= start_div_q;
`endif
                                step_strobe_q <= 1'b1;
                            end else begin
                                divider_q     <= next_div_d;
                                step_strobe_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.nco_en      = nco_en_q;
    assign bus.divider     = divider_q;
    assign bus.busy        = busy_q;
    assign bus.step_strobe = step_strobe_q;
    assign bus.done        = done_q;

endmodule
